sync_fifo_param: RTL and testbench
==================================

// Module: sync_fifo_param
// PURPOSE
//  Single-clock, parametrised successor to the 4-bit x 8 FIFO. Width, depth and watermark
//  levels are configurable, and depth need not be a power of two. Provides an occupancy
//  count, almost-full/almost-empty watermarks and push-while-full-with-pop. Sits between
//  the switch/debounce front end and the display/consumer logic in the one-clock domain.
// PARAMETERS
//  WIDTH     4  data word width in bits (>=1)
//  DEPTH     8  number of entries (>=2, any integer)
//  AF_LEVEL  6  Almost_Full asserted when Count >= AF_LEVEL (1..DEPTH)
//  AE_LEVEL  2  Almost_Empty asserted when Count <= AE_LEVEL (0..DEPTH-1)
// PORTS
//  CLK           in   1          single clock; all state on rising edge
//  rst           in   1          asynchronous, active-high reset
//  push          in   1          write request
//  pop           in   1          read request
//  Data_In       in   WIDTH      write data, sampled with push
//  Data_Out      out  WIDTH      registered read data
//  Data_Valid    out  1          1-cycle pulse: Data_Out updated this cycle
//  Full          out  1          Count == DEPTH
//  Empty         out  1          Count == 0
//  Almost_Full   out  1          Count >= AF_LEVEL
//  Almost_Empty  out  1          Count <= AE_LEVEL
//  Count         out  CNT_W      occupancy, CNT_W = $clog2(DEPTH+1)
// BEHAVIOUR
//  - Reset: wr_ptr=rd_ptr=0, Count=0, Data_Out=0, Data_Valid=0. Outputs therefore read
//    Empty=1, Full=0, Almost_Empty=1, Almost_Full=(AF_LEVEL==0 ? 1 : 0).
//    Memory contents are not cleared. Reset mid-operation discards all stored words at once.
//  - pop_acc  = pop  & !Empty.
//  - push_acc = push & (!Full | pop_acc). Push into a full FIFO is accepted only when a pop
//    is accepted in the same cycle.
//  - Push to an empty FIFO does not make data poppable until the following cycle.
//  - Write: on push_acc, mem[wr_ptr] <= Data_In.
//  - Read: on pop_acc, Data_Out <= mem[rd_ptr] and Data_Valid <= 1, i.e. one-cycle latency.
//    Otherwise Data_Valid <= 0 and Data_Out holds its last value.
//  - Pointers are ADDR_W = $clog2(DEPTH) bits wide and wrap explicitly: ptr==DEPTH-1 -> 0.
//  - Count <= Count + push_acc - pop_acc. Simultaneous accepted push and pop leaves Count
//    unchanged; the read returns the old word even when the write hits the same slot.
//  - Full, Empty, Almost_Full and Almost_Empty decode from the registered Count only, with
//    no combinational path from push/pop. Count is never < 0 and never > DEPTH.
//  - Rejected push/pop requests are silently dropped, with no state change.
// CONFIGURATION
//  SYNC_FIFO_ERR_EN defined: adds ports
//    Err_Clr   in   1   synchronous clear of the sticky flags
//    Overflow  out  1   sticky; set by push & !push_acc
//    Underflow out  1   sticky; set by pop & Empty
//  - Both flags are cleared by rst or Err_Clr. Err_Clr wins over a same-cycle set.
//  SYNC_FIFO_ERR_EN undefined: these ports and their logic are absent; behaviour is otherwise
//  identical.
// STRUCTURE
//  - Package fifo_pkg: clog2 helper, derived ADDR_W/CNT_W constants, and the pointer-increment
//    wrap function.
//  - One sub-module, fifo_ram: WIDTH x DEPTH array with one synchronous write port and one
//    synchronous registered read port (read enable = pop_acc).
//  - Pointer, count and flag logic stay in sync_fifo_param.
// TESTING (defaults WIDTH=4 DEPTH=8 AF=6 AE=2 unless noted)
//  1. Reset, then push 0x1..0x8 -> Count 1..8; Almost_Full from Count=6; Full at 8, Empty=0;
//     a 9th push with pop=0 is dropped and Count stays 8.
//  2. Pop 8 times -> Data_Out 0x1..0x8, each one cycle after its pop with a Data_Valid
//     pulse; Empty at Count 0; a 9th pop gives Data_Valid=0 and Data_Out holds 0x8.
//  3. Full, then push 0xA together with pop -> Data_Out = oldest word, Count stays 8,
//     0xA is read last.
//  4. DEPTH=5: push/pop 13 words in a streaming pattern -> pointers wrap 4->0, all data
//     returned in order, Count never exceeds 5.
//  5. Assert rst with Count=5 mid-stream -> the same cycle gives Empty=1, Count=0,
//     Data_Valid=0, Data_Out=0; the next push/pop sequence behaves as after power-up.
//  6. SYNC_FIFO_ERR_EN: pop while empty -> Underflow=1 until Err_Clr; push while full with
//     no pop -> Overflow=1; Err_Clr and a new error in the same cycle -> flag reads 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared sizing helpers and pointer-wrap function for the parametrised single-clock FIFO.
package fifo_pkg;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) res = i + 1;
        end
        return res;
    endfunction

    function automatic int unsigned addr_w(input int unsigned depth);
        return clog2(depth);
    endfunction

    // Count must hold DEPTH itself, hence the +1.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return clog2(depth + 1);
    endfunction

    // Explicit wrap so non-power-of-two depths never address past the last entry.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// WIDTH x DEPTH storage: one synchronous write port, one registered read port (reset to 0).
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned ADDR_W = addr_w(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q, rdata_d;

    // Storage is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re_i) rdata_d = mem_q[raddr_i];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rdata_q <= '0;
        else       rdata_q <= rdata_d;
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count and watermarks.
// Optional sticky Overflow/Underflow flags when SYNC_FIFO_ERR_EN is defined.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned AF_LEVEL = 6,
    parameter int unsigned AE_LEVEL = 2,
    localparam int unsigned ADDR_W  = addr_w(DEPTH),
    localparam int unsigned CNT_W   = cnt_w(DEPTH)
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] Data_In,
    output logic [WIDTH-1:0] Data_Out,
    output logic             Data_Valid,
    output logic             Full,
    output logic             Empty,
    output logic             Almost_Full,
    output logic             Almost_Empty,
`ifdef SYNC_FIFO_ERR_EN
    input  logic             Err_Clr,
    output logic             Overflow,
    output logic             Underflow,
`endif
    output logic [CNT_W-1:0] Count
);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              valid_q, valid_d;
    logic              push_acc, pop_acc;

    // Status decodes from registered count only; no path from push/pop.
    assign Full         = (count_q == CNT_W'(DEPTH));
    assign Empty        = (count_q == '0);
    assign Almost_Full  = (count_q >= CNT_W'(AF_LEVEL));
    assign Almost_Empty = (count_q <= CNT_W'(AE_LEVEL));

    assign pop_acc  = pop & ~Empty;
    assign push_acc = push & (~Full | pop_acc);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_acc) wr_ptr_d = ADDR_W'(ptr_inc(32'(wr_ptr_q), DEPTH));
        if (pop_acc)  rd_ptr_d = ADDR_W'(ptr_inc(32'(rd_ptr_q), DEPTH));
        count_d = count_q + CNT_W'(push_acc) - CNT_W'(pop_acc);
        valid_d = pop_acc;
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i   (CLK),
        .rst_i   (rst),
        .we_i    (push_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (Data_In),
        .re_i    (pop_acc),
        .raddr_i (rd_ptr_q),
        .rdata_o (Data_Out)
    );

    assign Data_Valid = valid_q;
    assign Count      = count_q;

`ifdef SYNC_FIFO_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Clear has priority over a same-cycle set.
    always_comb begin
        overflow_d  = overflow_q | (push & ~push_acc);
        underflow_d = underflow_q | (pop & Empty);
        if (Err_Clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign Overflow  = overflow_q;
    assign Underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: default 4x8 instance plus a depth-5 instance.
// Error-flag checks are included when SYNC_FIFO_ERR_EN is defined.
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       push, pop;
    logic [3:0] din;
    logic [3:0] dout;
    logic       dv, full, empty, afull, aempty;
    logic [3:0] count;

    logic       push5, pop5;
    logic [3:0] din5;
    logic [3:0] dout5;
    logic       dv5, full5, empty5, afull5, aempty5;
    logic [2:0] count5;

`ifdef SYNC_FIFO_ERR_EN
    logic err_clr, ovf, unf;
    logic err_clr5, ovf5, unf5;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sync_fifo_param #(
        .WIDTH    (4),
        .DEPTH    (8),
        .AF_LEVEL (6),
        .AE_LEVEL (2)
    ) u_dut (
        .CLK          (clk),
        .rst          (rst),
        .push         (push),
        .pop          (pop),
        .Data_In      (din),
        .Data_Out     (dout),
        .Data_Valid   (dv),
        .Full         (full),
        .Empty        (empty),
        .Almost_Full  (afull),
        .Almost_Empty (aempty),
`ifdef SYNC_FIFO_ERR_EN
        .Err_Clr      (err_clr),
        .Overflow     (ovf),
        .Underflow    (unf),
`endif
        .Count        (count)
    );

    sync_fifo_param #(
        .WIDTH    (4),
        .DEPTH    (5),
        .AF_LEVEL (4),
        .AE_LEVEL (1)
    ) u_d5 (
        .CLK          (clk),
        .rst          (rst),
        .push         (push5),
        .pop          (pop5),
        .Data_In      (din5),
        .Data_Out     (dout5),
        .Data_Valid   (dv5),
        .Full         (full5),
        .Empty        (empty5),
        .Almost_Full  (afull5),
        .Almost_Empty (aempty5),
`ifdef SYNC_FIFO_ERR_EN
        .Err_Clr      (err_clr5),
        .Overflow     (ovf5),
        .Underflow    (unf5),
`endif
        .Count        (count5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; push = 1'b0; pop = 1'b0; din = '0;
        push5 = 1'b0; pop5 = 1'b0; din5 = '0;
`ifdef SYNC_FIFO_ERR_EN
        err_clr = 1'b0; err_clr5 = 1'b0;
`endif
        #2;
        chk("rst_empty",  32'(empty),  1);
        chk("rst_full",   32'(full),   0);
        chk("rst_aempty", 32'(aempty), 1);
        chk("rst_afull",  32'(afull),  0);
        chk("rst_count",  32'(count),  0);
        chk("rst_dout",   32'(dout),   0);
        chk("rst_dv",     32'(dv),     0);
        tick();
        tick();
        rst = 1'b0;

        // Fill 0x1..0x8, then a dropped 9th push.
        for (int i = 1; i <= 8; i++) begin
            push = 1'b1; din = 4'(i);
            tick();
            chk("fill_count",  32'(count),  32'(i));
            chk("fill_afull",  32'(afull),  (i >= 6) ? 1 : 0);
            chk("fill_aempty", 32'(aempty), (i <= 2) ? 1 : 0);
            chk("fill_full",   32'(full),   (i == 8) ? 1 : 0);
            chk("fill_empty",  32'(empty),  0);
        end
        din = 4'hF;
        tick();
        chk("push_full_count", 32'(count), 8);
        chk("push_full_full",  32'(full),  1);
        push = 1'b0;

        // Drain in order, then an extra pop on empty.
        for (int i = 1; i <= 8; i++) begin
            pop = 1'b1;
            tick();
            chk("drain_dv",    32'(dv),    1);
            chk("drain_dout",  32'(dout),  32'(i));
            chk("drain_count", 32'(count), 32'(8 - i));
            chk("drain_empty", 32'(empty), (i == 8) ? 1 : 0);
        end
        tick();
        chk("pop_empty_dv",    32'(dv),    0);
        chk("pop_empty_dout",  32'(dout),  8);
        chk("pop_empty_count", 32'(count), 0);
        pop = 1'b0;

        // Push+pop on empty: pop rejected, word becomes poppable next cycle.
        push = 1'b1; pop = 1'b1; din = 4'h5;
        tick();
        chk("pp_empty_count", 32'(count), 1);
        chk("pp_empty_dv",    32'(dv),    0);
        push = 1'b0;
        tick();
        chk("pp_empty_dout", 32'(dout), 5);
        chk("pp_empty_dv2",  32'(dv),   1);
        pop = 1'b0;

        // Full, then push 0xA with pop.
        for (int i = 0; i < 8; i++) begin
            push = 1'b1; din = 4'(i + 2);
            tick();
        end
        chk("full2_full", 32'(full), 1);
        pop = 1'b1; din = 4'hA;
        tick();
        chk("fullpp_dout",  32'(dout),  2);
        chk("fullpp_dv",    32'(dv),    1);
        chk("fullpp_count", 32'(count), 8);
        chk("fullpp_full",  32'(full),  1);
        push = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("fullpp_drain", 32'(dout), (i == 7) ? 32'hA : 32'(i + 3));
        end
        chk("fullpp_end_empty", 32'(empty), 1);
        pop = 1'b0;

        // DEPTH=5 streaming: fill 5, 8 push+pop cycles, drain 5 (13 words, several wraps).
        for (int k = 0; k < 5; k++) begin
            push5 = 1'b1; din5 = 4'(k + 1);
            tick();
            chk("d5_fill_count", 32'(count5), 32'(k + 1));
        end
        chk("d5_full", 32'(full5), 1);
        pop5 = 1'b1;
        for (int k = 5; k < 13; k++) begin
            din5 = 4'(k + 1);
            tick();
            chk("d5_stream_dout",  32'(dout5),  32'(k - 4));
            chk("d5_stream_dv",    32'(dv5),    1);
            chk("d5_stream_count", 32'(count5), 5);
        end
        push5 = 1'b0;
        for (int k = 9; k <= 13; k++) begin
            tick();
            chk("d5_drain_dout",  32'(dout5),  32'(k));
            chk("d5_drain_count", 32'(count5), 32'(13 - k));
        end
        chk("d5_empty", 32'(empty5), 1);
        pop5 = 1'b0;

        // Asynchronous reset mid-stream with Count=5.
        for (int i = 0; i < 5; i++) begin
            push = 1'b1; din = 4'(i + 7);
            tick();
        end
        push = 1'b1; pop = 1'b1; din = 4'h3;
        tick();
        chk("pre_rst_count", 32'(count), 5);
        chk("pre_rst_dout",  32'(dout),  7);
        push = 1'b0; pop = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_empty", 32'(empty), 1);
        chk("arst_count", 32'(count), 0);
        chk("arst_dv",    32'(dv),    0);
        chk("arst_dout",  32'(dout),  0);
        tick();
        rst = 1'b0;
        push = 1'b1; din = 4'hC;
        tick();
        chk("post_rst_count", 32'(count), 1);
        push = 1'b0; pop = 1'b1;
        tick();
        chk("post_rst_dout",  32'(dout),  32'hC);
        chk("post_rst_dv",    32'(dv),    1);
        chk("post_rst_empty", 32'(empty), 1);
        pop = 1'b0;
        tick();

`ifdef SYNC_FIFO_ERR_EN
        chk("err_init_unf", 32'(unf), 0);
        pop = 1'b1;
        tick();
        chk("unf_set", 32'(unf), 1);
        pop = 1'b0;
        tick();
        chk("unf_sticky", 32'(unf), 1);
        err_clr = 1'b1;
        tick();
        chk("unf_clr", 32'(unf), 0);
        err_clr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push = 1'b1; din = 4'(i);
            tick();
        end
        chk("ovf_none_yet", 32'(ovf), 0);
        tick();
        chk("ovf_set", 32'(ovf), 1);
        err_clr = 1'b1;
        tick();
        chk("ovf_clr_wins", 32'(ovf), 0);
        err_clr = 1'b0; push = 1'b0;
        tick();
        chk("ovf_stays_clr", 32'(ovf), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
